iram_arbiter: RTL and testbench
===============================

IRAM_ARBITER -- requirements
Module: iram_arbiter

Interface
REQ-001 The module SHALL have parameter MEM_DEPTH, default 1024, meaning the number of 32-bit words in the attached instruction RAM.
REQ-002 The module SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles a loader request can be denied.
REQ-003 Port: i_Clk  in  1  clock; all logic is on the rising edge.
REQ-004 Port: i_Rst  in  1  reset; synchronous, active-high.
REQ-005 Port: i_F_Req  in  1  CPU fetch request.
REQ-006 Port: i_F_Addr  in  32  CPU fetch byte address.
REQ-007 Port: o_F_Gnt  out  1  fetch accepted this cycle.
REQ-008 Port: o_F_Valid / o_F_Data / o_F_Err  out  1/32/1  fetch response, instruction word, error flag.
REQ-009 Port: o_F_Flush  out  1  one-cycle pulse telling the CPU to discard in-flight fetches and refetch.
REQ-010 Port: i_L_Req / i_L_We / i_L_Lock  in  1/1/1  loader request, write enable, exclusive-bus lock.
REQ-011 Port: i_L_Addr / i_L_WData  in  32/32  loader byte address and write data.
REQ-012 Port: o_L_Gnt / o_L_Valid / o_L_RData / o_L_Err  out  1/1/32/1  loader grant, read response, read data, error flag.
REQ-013 Port: o_M_Addr / o_M_We / o_M_WData  out  clog2(MEM_DEPTH)/1/32  RAM word address, write strobe, write data.
REQ-014 Port: i_M_RData  in  32  RAM read data, valid exactly one cycle after the address is presented.

Function
REQ-015 The FSM SHALL have three states: FETCH (default), LOAD (loader owns the RAM), and EXIT (one-cycle flush).
REQ-016 In FETCH, fetch SHALL have priority: o_F_Gnt = i_F_Req, and o_L_Gnt = i_L_Req & (!i_F_Req | starve_cnt == STARVE_LIMIT).
REQ-017 At most one grant SHALL be asserted per cycle, and the granted port's address, write enable and write data SHALL drive o_M_* combinationally in that cycle.
REQ-018 The 4-bit starve_cnt SHALL increment each cycle that i_L_Req=1 and o_L_Gnt=0, clear on a loader grant, and saturate at STARVE_LIMIT.
REQ-019 The word address SHALL be i_*_Addr[clog2(MEM_DEPTH)+1:2].
REQ-020 Read responses SHALL have a latency of 1 cycle: the cycle after a read grant, the granted port's Valid=1 and Data = i_M_RData.
REQ-021 A loader write SHALL pulse o_M_We for exactly the grant cycle and SHALL produce no o_L_Valid.
REQ-022 When i_L_Lock=1 together with a loader grant in FETCH, the FSM SHALL enter LOAD on the next cycle.
REQ-023 In LOAD, o_F_Gnt SHALL be 0 and o_L_Gnt SHALL equal i_L_Req.
REQ-024 In LOAD, when i_L_Lock=0 and no loader response is outstanding, the FSM SHALL go to EXIT.
REQ-025 In EXIT, o_F_Flush=1, both grants SHALL be 0, and the FSM SHALL return to FETCH next cycle.
REQ-026 A fetch response already in flight when LOAD is entered SHALL still be delivered.
REQ-027 Ungranted requesters SHALL hold their request and payload stable until granted.

Reset
REQ-028 While i_Rst=1: the FSM SHALL be in FETCH, starve_cnt=0, and all o_* outputs SHALL be 0, including o_M_We.
REQ-029 Reset mid-operation SHALL drop any in-flight response, so Valid=0 in the cycle after reset deasserts, and SHALL abandon LOAD without a flush pulse.

Configuration
REQ-030 With macro IRAM_ARB_ERR_EN defined, a granted access with Addr[1:0]!=0 or word address >= MEM_DEPTH SHALL suppress o_M_We, return Data=0, and raise Err with Valid one cycle later; a write error SHALL also produce a Valid pulse.
REQ-031 Without IRAM_ARB_ERR_EN, Addr[1:0] SHALL be ignored, addresses SHALL wrap modulo MEM_DEPTH, and o_F_Err/o_L_Err SHALL be tied to 0.

Verification
REQ-032 Fetch at 0x0, 0x4, 0x8 on consecutive cycles with RAM words 0x00002283, 0x10501023, 0x00402583 -> o_F_Valid=1 on cycles +1, +2, +3 with those words in order.
REQ-033 i_F_Req held at 1 and i_L_Req=1 (write, addr 0x10) -> o_L_Gnt=1 on the 5th cycle (starve_cnt=4), o_M_We=1 that cycle only, and starve_cnt=0 afterwards.
REQ-034 Loader with i_L_Lock=1 writes 3 words then drops the lock -> no o_F_Gnt during LOAD, o_F_Flush pulses exactly one cycle, and fetch resumes the cycle after.
REQ-035 With ERR_EN, fetch at 0x6 and at 0x1000 (depth 1024) -> o_F_Err=1 and Data=0 for each, with no o_M_We; without ERR_EN, 0x1000 returns word 0.
REQ-036 i_Rst asserted the cycle after a read grant and while in LOAD -> no Valid, no Flush, FSM in FETCH, and all outputs 0.

Source files
------------

// File: rtl/iram_arbiter.sv
// iram_arbiter: fetch/loader arbiter for a single-port instruction RAM; define IRAM_ARB_ERR_EN to enable address error checking
module iram_arbiter #(
   parameter int MEM_DEPTH    = 1024,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic                         i_F_Req,
   input  logic [31:0]                  i_F_Addr,
   output logic                         o_F_Gnt,
   output logic                         o_F_Valid,
   output logic [31:0]                  o_F_Data,
   output logic                         o_F_Err,
   output logic                         o_F_Flush,
   input  logic                         i_L_Req,
   input  logic                         i_L_We,
   input  logic                         i_L_Lock,
   input  logic [31:0]                  i_L_Addr,
   input  logic [31:0]                  i_L_WData,
   output logic                         o_L_Gnt,
   output logic                         o_L_Valid,
   output logic [31:0]                  o_L_RData,
   output logic                         o_L_Err,
   output logic [$clog2(MEM_DEPTH)-1:0] o_M_Addr,
   output logic                         o_M_We,
   output logic [31:0]                  o_M_WData,
   input  logic [31:0]                  i_M_RData
);
   localparam int AW = $clog2(MEM_DEPTH);
   typedef enum logic [1:0] {FETCH, LOAD, EXIT} state_t;
   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       f_vld_q, f_vld_d, f_err_q, f_err_d;
   logic       l_vld_q, l_vld_d, l_err_q, l_err_d;
   logic       f_gnt, l_gnt, f_bad, l_bad;
`ifdef IRAM_ARB_ERR_EN
   assign f_bad = (|i_F_Addr[1:0]) || ({2'b00, i_F_Addr[31:2]} >= 32'(MEM_DEPTH));
   assign l_bad = (|i_L_Addr[1:0]) || ({2'b00, i_L_Addr[31:2]} >= 32'(MEM_DEPTH));
`else
   logic unused_addr;
   assign f_bad = 1'b0;
   assign l_bad = 1'b0;
   assign unused_addr = ^{i_F_Addr[31:AW+2], i_F_Addr[1:0], i_L_Addr[31:AW+2], i_L_Addr[1:0]};
`endif
   // Arbitrate, steer the RAM port, compute next state and gate every output during reset
   always_comb begin
      l_gnt = !i_Rst && i_L_Req && (state_q == LOAD ||
              (state_q == FETCH && (!i_F_Req || starve_cnt_q == 4'(STARVE_LIMIT))));
      f_gnt = !i_Rst && state_q == FETCH && i_F_Req && !l_gnt;
      state_d = (state_q == FETCH && l_gnt && i_L_Lock) ? LOAD :
                (state_q == LOAD && !i_L_Lock && !(l_gnt && !i_L_We)) ? EXIT :
                (state_q == EXIT) ? FETCH : state_q;
      starve_cnt_d = l_gnt ? 4'd0 :
                     (i_L_Req && starve_cnt_q != 4'(STARVE_LIMIT)) ? starve_cnt_q + 4'd1 : starve_cnt_q;
      f_vld_d   = f_gnt;
      f_err_d   = f_gnt && f_bad;
      l_vld_d   = l_gnt && (!i_L_We || l_bad);
      l_err_d   = l_gnt && l_bad;
      o_F_Gnt   = f_gnt;
      o_L_Gnt   = l_gnt;
      o_M_Addr  = l_gnt ? i_L_Addr[AW+1:2] : f_gnt ? i_F_Addr[AW+1:2] : '0;
      o_M_We    = l_gnt && i_L_We && !l_bad;
      o_M_WData = l_gnt ? i_L_WData : '0;
      o_F_Valid = !i_Rst && f_vld_q;
      o_F_Err   = !i_Rst && f_err_q;
      o_F_Data  = (o_F_Valid && !f_err_q) ? i_M_RData : '0;
      o_L_Valid = !i_Rst && l_vld_q;
      o_L_Err   = !i_Rst && l_err_q;
      o_L_RData = (o_L_Valid && !l_err_q) ? i_M_RData : '0;
      o_F_Flush = !i_Rst && state_q == EXIT;
   end
   // Register FSM state, starvation count and pending responses
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q      <= FETCH;
         starve_cnt_q <= '0;
         f_vld_q      <= 1'b0;
         f_err_q      <= 1'b0;
         l_vld_q      <= 1'b0;
         l_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         f_vld_q      <= f_vld_d;
         f_err_q      <= f_err_d;
         l_vld_q      <= l_vld_d;
         l_err_q      <= l_err_d;
      end
   end
endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter: directed self-checking bench for iram_arbiter
module tb_iram_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
   logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
   logic        o_F_Gnt, o_F_Valid, o_F_Err, o_F_Flush;
   logic [31:0] o_F_Data, o_L_RData, o_M_WData;
   logic        o_L_Gnt, o_L_Valid, o_L_Err, o_M_We;
   logic [9:0]  o_M_Addr;
   logic [31:0] m_rdata;
   logic [31:0] mem [0:1023];
   logic        tb_we = 1'b0;
   logic [9:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;
   logic [31:0] words [0:2] = '{32'h00002283, 32'h10501023, 32'h00402583};
   int          checks = 0, failures = 0;
   wire         any_out = |{o_F_Gnt, o_F_Valid, o_F_Data, o_F_Err, o_F_Flush, o_L_Gnt,
                            o_L_Valid, o_L_RData, o_L_Err, o_M_Addr, o_M_We, o_M_WData};

   iram_arbiter dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_F_Req(f_req), .i_F_Addr(f_addr),
      .o_F_Gnt(o_F_Gnt), .o_F_Valid(o_F_Valid), .o_F_Data(o_F_Data), .o_F_Err(o_F_Err), .o_F_Flush(o_F_Flush),
      .i_L_Req(l_req), .i_L_We(l_we), .i_L_Lock(l_lock), .i_L_Addr(l_addr), .i_L_WData(l_wdata),
      .o_L_Gnt(o_L_Gnt), .o_L_Valid(o_L_Valid), .o_L_RData(o_L_RData), .o_L_Err(o_L_Err),
      .o_M_Addr(o_M_Addr), .o_M_We(o_M_We), .o_M_WData(o_M_WData), .i_M_RData(m_rdata)
   );

   always #5 clk = ~clk;

   // RAM model with one-cycle read latency and a bench-side preload port
   always @(posedge clk) begin
      if (tb_we) mem[tb_wa] <= tb_wd;
      else if (o_M_We) mem[o_M_Addr] <= o_M_WData;
      m_rdata <= mem[o_M_Addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
      l_addr = 32'h10; l_wdata = 32'hFFFF_FFFF;
      tick; tick; #1;
      checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL reset_outputs: some output nonzero, got %b expected 0", any_out); end
      checks++; if (dut.starve_cnt_q !== 4'd0) begin failures++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt_q); end
      for (int i = 0; i < 3; i++) begin
         tb_we = 1'b1; tb_wa = 10'(i); tb_wd = words[i];
         tick;
      end
      tb_we = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
      rst = 1'b0;
   endtask

   task automatic test_fetch_stream;
      for (int i = 0; i < 5; i++) begin
         tick;
         f_req = (i < 3); f_addr = 32'(4 * i);
         #1;
         if (i < 3) begin
            checks++; if (o_F_Gnt !== 1'b1 || o_M_Addr !== 10'(i)) begin failures++; $display("FAIL fetch_gnt[%0d]: gnt=%b addr=%0d expected gnt=1 addr=%0d", i, o_F_Gnt, o_M_Addr, i); end
         end
         if (i >= 1 && i <= 3) begin
            checks++; if (o_F_Valid !== 1'b1 || o_F_Data !== words[i-1]) begin failures++; $display("FAIL fetch_data[%0d]: valid=%b data=%h expected valid=1 data=%h", i, o_F_Valid, o_F_Data, words[i-1]); end
         end else begin
            checks++; if (o_F_Valid !== 1'b0) begin failures++; $display("FAIL fetch_idle[%0d]: valid=%b expected 0", i, o_F_Valid); end
         end
      end
   endtask

   task automatic test_starvation;
      for (int c = 1; c <= 5; c++) begin
         tick;
         f_req = 1'b1; f_addr = 32'h20; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hCAFE_F00D;
         #1;
         checks++; if (o_L_Gnt !== (c == 5) || o_F_Gnt !== (c != 5) || o_M_We !== (c == 5)) begin failures++; $display("FAIL starve_cycle%0d: lgnt=%b fgnt=%b we=%b expected lgnt=%b fgnt=%b we=%b", c, o_L_Gnt, o_F_Gnt, o_M_We, c == 5, c != 5, c == 5); end
         if (c == 5) begin
            checks++; if (o_M_Addr !== 10'd4 || o_M_WData !== 32'hCAFE_F00D) begin failures++; $display("FAIL starve_wr_payload: addr=%0d data=%h expected addr=4 data=cafef00d", o_M_Addr, o_M_WData); end
         end
      end
      tick;
      l_req = 1'b0; l_we = 1'b0; f_req = 1'b0;
      #1;
      checks++; if (o_M_We !== 1'b0 || o_L_Valid !== 1'b0) begin failures++; $display("FAIL starve_after: we=%b lvalid=%b expected 0 0", o_M_We, o_L_Valid); end
      checks++; if (dut.starve_cnt_q !== 4'd0) begin failures++; $display("FAIL starve_clear: got %0d expected 0", dut.starve_cnt_q); end
      checks++; if (mem[4] !== 32'hCAFE_F00D) begin failures++; $display("FAIL starve_mem: got %h expected cafef00d", mem[4]); end
   endtask

   task automatic test_lock;
      tick;
      f_req = 1'b1; f_addr = 32'h4;
      #1;
      checks++; if (o_F_Gnt !== 1'b1) begin failures++; $display("FAIL lock_pre_fetch: gnt=%b expected 1", o_F_Gnt); end
      tick;
      f_req = 1'b0; l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 32'h40; l_wdata = 32'hA000_0000;
      #1;
      checks++; if (o_L_Gnt !== 1'b1 || o_M_We !== 1'b1) begin failures++; $display("FAIL lock_first_wr: lgnt=%b we=%b expected 1 1", o_L_Gnt, o_M_We); end
      checks++; if (o_F_Valid !== 1'b1 || o_F_Data !== words[1]) begin failures++; $display("FAIL lock_inflight: valid=%b data=%h expected 1 %h", o_F_Valid, o_F_Data, words[1]); end
      for (int k = 1; k <= 2; k++) begin
         tick;
         f_req = 1'b1; f_addr = 32'h0; l_addr = 32'h40 + 32'(4 * k); l_wdata = 32'hA000_0000 + 32'(k);
         #1;
         checks++; if (o_L_Gnt !== 1'b1 || o_F_Gnt !== 1'b0 || o_M_We !== 1'b1 || o_F_Flush !== 1'b0) begin failures++; $display("FAIL lock_load%0d: lgnt=%b fgnt=%b we=%b flush=%b expected 1 0 1 0", k, o_L_Gnt, o_F_Gnt, o_M_We, o_F_Flush); end
      end
      tick;
      l_req = 1'b0; l_lock = 1'b0; l_we = 1'b0;
      #1;
      checks++; if (o_F_Gnt !== 1'b0 || o_F_Flush !== 1'b0) begin failures++; $display("FAIL lock_release: fgnt=%b flush=%b expected 0 0", o_F_Gnt, o_F_Flush); end
      tick; #1;
      checks++; if (o_F_Flush !== 1'b1 || o_F_Gnt !== 1'b0 || o_L_Gnt !== 1'b0) begin failures++; $display("FAIL lock_exit: flush=%b fgnt=%b lgnt=%b expected 1 0 0", o_F_Flush, o_F_Gnt, o_L_Gnt); end
      tick; #1;
      checks++; if (o_F_Flush !== 1'b0 || o_F_Gnt !== 1'b1 || o_M_Addr !== 10'd0) begin failures++; $display("FAIL lock_resume: flush=%b fgnt=%b addr=%0d expected 0 1 0", o_F_Flush, o_F_Gnt, o_M_Addr); end
      tick;
      f_req = 1'b0;
      #1;
      checks++; if (o_F_Valid !== 1'b1 || o_F_Data !== words[0]) begin failures++; $display("FAIL lock_resume_data: valid=%b data=%h expected 1 %h", o_F_Valid, o_F_Data, words[0]); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (mem[16+k] !== 32'hA000_0000 + 32'(k)) begin failures++; $display("FAIL lock_mem[%0d]: got %h expected %h", 16 + k, mem[16+k], 32'hA000_0000 + 32'(k)); end
      end
   endtask

   task automatic test_loader_read;
      tick;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
      #1;
      checks++; if (o_L_Gnt !== 1'b1 || o_M_We !== 1'b0 || o_M_Addr !== 10'd2) begin failures++; $display("FAIL lread_gnt: gnt=%b we=%b addr=%0d expected 1 0 2", o_L_Gnt, o_M_We, o_M_Addr); end
      tick;
      l_req = 1'b0;
      #1;
      checks++; if (o_L_Valid !== 1'b1 || o_L_RData !== words[2] || o_F_Valid !== 1'b0) begin failures++; $display("FAIL lread_data: lvalid=%b data=%h fvalid=%b expected 1 %h 0", o_L_Valid, o_L_RData, o_F_Valid, words[2]); end
      tick; #1;
      checks++; if (o_L_Valid !== 1'b0) begin failures++; $display("FAIL lread_once: lvalid=%b expected 0", o_L_Valid); end
   endtask

   task automatic test_addr_bounds;
      logic [31:0] addrs [0:1];
      int          widx [0:1];
      addrs = '{32'h6, 32'h1000};
      widx = '{1, 0};
      for (int i = 0; i < 2; i++) begin
         tick;
         f_req = 1'b1; f_addr = addrs[i];
         #1;
         checks++; if (o_F_Gnt !== 1'b1 || o_M_We !== 1'b0) begin failures++; $display("FAIL bound_gnt[%h]: gnt=%b we=%b expected 1 0", addrs[i], o_F_Gnt, o_M_We); end
`ifndef IRAM_ARB_ERR_EN
         checks++; if (o_M_Addr !== 10'(widx[i])) begin failures++; $display("FAIL bound_wrap[%h]: addr=%0d expected %0d", addrs[i], o_M_Addr, widx[i]); end
`endif
         tick;
         f_req = 1'b0;
         #1;
`ifdef IRAM_ARB_ERR_EN
         checks++; if (o_F_Valid !== 1'b1 || o_F_Err !== 1'b1 || o_F_Data !== 32'h0) begin failures++; $display("FAIL bound_err[%h]: valid=%b err=%b data=%h expected 1 1 0", addrs[i], o_F_Valid, o_F_Err, o_F_Data); end
`else
         checks++; if (o_F_Valid !== 1'b1 || o_F_Err !== 1'b0 || o_F_Data !== words[widx[i]]) begin failures++; $display("FAIL bound_data[%h]: valid=%b err=%b data=%h expected 1 0 %h", addrs[i], o_F_Valid, o_F_Err, o_F_Data, words[widx[i]]); end
`endif
      end
`ifdef IRAM_ARB_ERR_EN
      tick;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h1002; l_wdata = 32'h1234_5678;
      #1;
      checks++; if (o_L_Gnt !== 1'b1 || o_M_We !== 1'b0) begin failures++; $display("FAIL bound_lwr: gnt=%b we=%b expected 1 0", o_L_Gnt, o_M_We); end
      tick;
      l_req = 1'b0; l_we = 1'b0;
      #1;
      checks++; if (o_L_Valid !== 1'b1 || o_L_Err !== 1'b1 || o_L_RData !== 32'h0) begin failures++; $display("FAIL bound_lwr_err: valid=%b err=%b data=%h expected 1 1 0", o_L_Valid, o_L_Err, o_L_RData); end
`endif
   endtask

   task automatic test_reset_mid;
      tick;
      f_req = 1'b1; f_addr = 32'h8;
      #1;
      checks++; if (o_F_Gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt: gnt=%b expected 1", o_F_Gnt); end
      tick;
      f_req = 1'b0; rst = 1'b1;
      #1;
      checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL rmid_rd_outputs: any=%b expected 0", any_out); end
      tick;
      rst = 1'b0;
      #1;
      checks++; if (o_F_Valid !== 1'b0) begin failures++; $display("FAIL rmid_dropped: valid=%b expected 0", o_F_Valid); end
      tick;
      l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'h1;
      #1;
      checks++; if (o_L_Gnt !== 1'b1) begin failures++; $display("FAIL rmid_lock_gnt: gnt=%b expected 1", o_L_Gnt); end
      tick;
      rst = 1'b1;
      #1;
      checks++; if (any_out !== 1'b0) begin failures++; $display("FAIL rmid_load_outputs: any=%b expected 0", any_out); end
      tick;
      rst = 1'b0; l_req = 1'b0; l_lock = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h0;
      #1;
      checks++; if (o_F_Gnt !== 1'b1 || o_F_Flush !== 1'b0) begin failures++; $display("FAIL rmid_fetch_state: gnt=%b flush=%b expected 1 0", o_F_Gnt, o_F_Flush); end
      tick;
      f_req = 1'b0;
      #1;
      checks++; if (o_F_Flush !== 1'b0 || o_F_Valid !== 1'b1 || o_F_Data !== words[0]) begin failures++; $display("FAIL rmid_after: flush=%b valid=%b data=%h expected 0 1 %h", o_F_Flush, o_F_Valid, o_F_Data, words[0]); end
   endtask

   initial begin
      test_reset;
      test_fetch_stream;
      test_starvation;
      test_lock;
      test_loader_read;
      test_addr_bounds;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
